lo_gen_multi: RTL and testbench

//  Multi-channel LO generator; parametrised successor of the single-channel mixer LO control.
//  Per channel: internal divided LO (differential 50% or quadrature 4-phase 25%) or synchronised external LO.

---
 rtl/mixer_lo_pkg.sv | 24 ++
 rtl/lo_chan.sv | 164 ++++++++++++++++
 rtl/lo_gen_multi.sv | 63 ++++++
 tb/tb_lo_gen_multi.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_lo_pkg.sv
// Shared types for the multi-channel LO generator.
// Optional dead time per phase is enabled with LO_DEADTIME_EN.
package mixer_lo_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        LO_OFF  = 2'b00,
        LO_DIFF = 2'b01,
        LO_QUAD = 2'b10,
        LO_EXT  = 2'b11
    } lo_mode_e;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        GAP = 2'd1,
        RUN = 2'd2
    } lo_state_e;

    function automatic logic [1:0] last_phase(lo_mode_e m);
        return (m == LO_QUAD) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/lo_chan.sv
// One LO channel: config shadow, OFF/GAP/RUN FSM, phase counter, ext sync.
// LO_DEADTIME_EN blanks the first DEAD_CYC cycles of each internal phase.
module lo_chan
    import mixer_lo_pkg::*;
#(
    parameter int DIV_W    = 8,
    parameter int DEAD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic              sync_i,
    input  logic              ext_p,
    input  logic              ext_n,
    output logic              busy,
    output logic              lo_p,
    output logic              lo_n,
    output logic              lo_qp,
    output logic              lo_qn
);

`ifdef LO_DEADTIME_EN
    localparam int DEAD_EN = 1;
`else
    localparam int DEAD_EN = 0;
`endif
    localparam int DEAD_EFF = DEAD_EN * DEAD_CYC;

    lo_state_e        state_q, state_d;
    lo_mode_e         shm_q, shm_d, mode_q, mode_d;
    logic [DIV_W-1:0] shd_q, shd_d, div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ph_q, ph_d;
    logic             busy_q, busy_d;
    logic             ep1_q, ep2_q, en1_q, en2_q;
    logic             p_q, n_q, qp_q, qn_q;
    logic             p_d, n_d, qp_d, qn_d;
    logic             wrap, bnd, live;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        shm_d   = shm_q;
        shd_d   = shd_q;
        mode_d  = mode_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        wrap    = (cnt_q == div_q);
        bnd     = (mode_q == LO_EXT) ||
                  (wrap && ph_q == last_phase(mode_q));
        unique case (state_q)
            OFF: if (busy_q) state_d = GAP;
            GAP: begin
                state_d = (mode_q != LO_OFF) ? RUN : OFF;
                cnt_d   = '0;
                ph_d    = '0;
            end
            RUN: begin
                // a pending config beats sync_i at the boundary
                if (busy_q && bnd) begin
                    state_d = GAP;
                end else if (sync_i && mode_q != LO_EXT) begin
                    cnt_d = '0;
                    ph_d  = '0;
                end else if (wrap) begin
                    cnt_d = '0;
                    ph_d  = (ph_q == last_phase(mode_q)) ? 2'd0 : ph_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = OFF;
        endcase
        if (state_d == GAP && state_q != GAP) begin
            mode_d = shm_q;
            div_d  = shd_q;
            busy_d = 1'b0;
            cnt_d  = '0;
            ph_d   = '0;
        end
        if (wr_en) begin
            busy_d = 1'b1;
            shm_d  = lo_mode_e'(wr_mode);
            shd_d  = wr_div;
        end
    end

    // outputs are a registered decode of the next state
    always_comb begin
        p_d  = 1'b0;
        n_d  = 1'b0;
        qp_d = 1'b0;
        qn_d = 1'b0;
        live = (32'(cnt_d) >= 32'(DEAD_EFF));
        if (state_d == RUN) begin
            unique case (mode_d)
                LO_DIFF: begin
                    p_d = live && ph_d == 2'd0;
                    n_d = live && ph_d == 2'd1;
                end
                LO_QUAD: begin
                    p_d  = live && ph_d == 2'd0;
                    qp_d = live && ph_d == 2'd1;
                    n_d  = live && ph_d == 2'd2;
                    qn_d = live && ph_d == 2'd3;
                end
                LO_EXT: begin
                    p_d = ep2_q && !en2_q;
                    n_d = en2_q && !ep2_q;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            busy_q  <= 1'b0;
            shm_q   <= LO_OFF;
            shd_q   <= '0;
            mode_q  <= LO_OFF;
            div_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            ep1_q   <= 1'b0;
            ep2_q   <= 1'b0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            p_q     <= 1'b0;
            n_q     <= 1'b0;
            qp_q    <= 1'b0;
            qn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            shm_q   <= shm_d;
            shd_q   <= shd_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            ep1_q   <= ext_p;
            ep2_q   <= ep1_q;
            en1_q   <= ext_n;
            en2_q   <= en1_q;
            p_q     <= p_d;
            n_q     <= n_d;
            qp_q    <= qp_d;
            qn_q    <= qn_d;
        end
    end

    assign busy  = busy_q;
    assign lo_p  = p_q;
    assign lo_n  = n_q;
    assign lo_qp = qp_q;
    assign lo_qn = qn_q;

endmodule

// File: rtl/lo_gen_multi.sv
// Multi-channel LO generator top: config routing, ready mux, sync fan-out.
// Dead time per phase is compiled in with LO_DEADTIME_EN.
module lo_gen_multi
    import mixer_lo_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int DIV_W    = 8,
    parameter int DEAD_CYC = 1,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync_i,
    input  logic [N_CH-1:0]   ext_lo_p,
    input  logic [N_CH-1:0]   ext_lo_n,
    output logic [N_CH-1:0]   lo_p,
    output logic [N_CH-1:0]   lo_n,
    output logic [N_CH-1:0]   lo_qp,
    output logic [N_CH-1:0]   lo_qn,
    output logic [N_CH-1:0]   busy
);

    logic [N_CH-1:0] wr_en;

    // an out-of-range channel stays ready and its write is dropped
    always_comb begin
        cfg_ready = 1'b1;
        wr_en     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !busy[i];
                wr_en[i]  = cfg_valid && !busy[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        lo_chan #(
            .DIV_W   (DIV_W),
            .DEAD_CYC(DEAD_CYC)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_en[g]),
            .wr_mode(cfg_mode),
            .wr_div (cfg_div),
            .sync_i (sync_i),
            .ext_p  (ext_lo_p[g]),
            .ext_n  (ext_lo_n[g]),
            .busy   (busy[g]),
            .lo_p   (lo_p[g]),
            .lo_n   (lo_n[g]),
            .lo_qp  (lo_qp[g]),
            .lo_qn  (lo_qn[g])
        );
    end

endmodule

// File: tb/tb_lo_gen_multi.sv
// Randomised bench for lo_gen_multi against a position-based timing model.
// Build with LO_DEADTIME_EN to check the dead-time variant.
module tb_lo_gen_multi;

    localparam int N    = 2;
    localparam int DW   = 8;
    localparam int DEAD = 1;
`ifdef LO_DEADTIME_EN
    localparam bit DEADEN = 1'b1;
`else
    localparam bit DEADEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [0:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          sync_i = 1'b0;
    logic [N-1:0]  ext_lo_p = '0;
    logic [N-1:0]  ext_lo_n = '0;
    logic [N-1:0]  lo_p, lo_n, lo_qp, lo_qn, busy;

    int checks = 0;
    int errors = 0;

    lo_gen_multi #(.N_CH(N), .DIV_W(DW), .DEAD_CYC(DEAD)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_div  (cfg_div),
        .sync_i   (sync_i),
        .ext_lo_p (ext_lo_p),
        .ext_lo_n (ext_lo_n),
        .lo_p     (lo_p),
        .lo_n     (lo_n),
        .lo_qp    (lo_qp),
        .lo_qn    (lo_qn),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: state 0 OFF, 1 GAP, 2 RUN; RUN position = cycles since t0
    int mst[N], mbusy[N], shm[N], shd[N], am[N], ad[N], t0[N];
    bit hp[N][8], hn[N][8];
    int k = 0;

    function automatic int period(int c);
        return (ad[c] + 1) * ((am[c] == 2) ? 4 : 2);
    endfunction

    task automatic m_reset();
        for (int c = 0; c < N; c++) begin
            mst[c] = 0; mbusy[c] = 0; shm[c] = 0; shd[c] = 0;
            am[c] = 0; ad[c] = 0; t0[c] = 0;
            hp[c][k % 8] = 1'b0;
            hn[c][k % 8] = 1'b0;
        end
    endtask

    task automatic m_gap(input int c);
        mst[c] = 1; am[c] = shm[c]; ad[c] = shd[c]; mbusy[c] = 0;
    endtask

    task automatic m_step();
        bit acc;
        int ch;
        ch  = int'(cfg_ch);
        acc = cfg_valid && (ch >= N || mbusy[ch] == 0);
        for (int c = 0; c < N; c++) begin
            case (mst[c])
                0: if (mbusy[c] != 0) m_gap(c);
                1: begin
                    if (am[c] != 0) begin mst[c] = 2; t0[c] = k; end
                    else mst[c] = 0;
                end
                default: begin
                    if (mbusy[c] != 0 && (am[c] == 3 ||
                        (k - 1 - t0[c]) % period(c) == period(c) - 1))
                        m_gap(c);
                    else if (sync_i && am[c] != 3)
                        t0[c] = k;
                end
            endcase
            if (acc && ch == c) begin
                mbusy[c] = 1; shm[c] = int'(cfg_mode); shd[c] = int'(cfg_div);
            end
            hp[c][k % 8] = ext_lo_p[c];
            hn[c][k % 8] = ext_lo_n[c];
        end
    endtask

    task automatic m_check();
        bit ep, en, eqp, eqn, live, a, b;
        int pos, ph, cn, ch;
        for (int c = 0; c < N; c++) begin
            ep = 0; en = 0; eqp = 0; eqn = 0;
            if (mst[c] == 2) begin
                if (am[c] == 3) begin
                    a = hp[c][(k + 6) % 8];
                    b = hn[c][(k + 6) % 8];
                    ep = a && !b;
                    en = b && !a;
                end else begin
                    pos  = (k - t0[c]) % period(c);
                    ph   = pos / (ad[c] + 1);
                    cn   = pos % (ad[c] + 1);
                    live = !(DEADEN && cn < DEAD);
                    if (am[c] == 1) begin
                        ep = live && ph == 0;
                        en = live && ph == 1;
                    end else begin
                        ep  = live && ph == 0;
                        eqp = live && ph == 1;
                        en  = live && ph == 2;
                        eqn = live && ph == 3;
                    end
                end
            end
            chk($sformatf("lo_p[%0d]", c), 32'(lo_p[c]), 32'(ep));
            chk($sformatf("lo_n[%0d]", c), 32'(lo_n[c]), 32'(en));
            chk($sformatf("lo_qp[%0d]", c), 32'(lo_qp[c]), 32'(eqp));
            chk($sformatf("lo_qn[%0d]", c), 32'(lo_qn[c]), 32'(eqn));
            chk($sformatf("busy[%0d]", c), 32'(busy[c]), 32'(mbusy[c] != 0));
        end
        ch = int'(cfg_ch);
        chk("cfg_ready", 32'(cfg_ready), 32'(ch >= N || mbusy[ch] == 0));
        chk("overlap", 32'(|((lo_p & lo_n) | (lo_qp & lo_qn))), 32'd0);
    endtask

    always @(posedge clk) begin
        k++;
        if (rst) begin
            m_reset();
        end else begin
            m_step();
            #1;
            m_check();
        end
    end

    task automatic wr(input int ch, input int mode, input int div);
        int n;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_mode  = 2'(mode);
        cfg_div   = DW'(div);
        #1;
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("wr_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    logic [5:0]  pv, nv;
    logic [15:0] qv;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_lo", 32'({lo_p, lo_n, lo_qp, lo_qn}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        // ch0 DIFF div=2 from OFF
        wr(0, 1, 2);
        chk("t1_busy1", 32'(busy[0]), 32'd1);
        chk("t1_ready0", 32'(cfg_ready), 32'd0);
        @(posedge clk); #2;
        chk("t1_busy0", 32'(busy[0]), 32'd0);
        chk("t1_gap", 32'(lo_p[0] | lo_n[0]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            pv[5-i] = lo_p[0];
            nv[5-i] = lo_n[0];
        end
`ifdef LO_DEADTIME_EN
        chk("t1_pat_p", 32'(pv), 32'b011000);
        chk("t1_pat_n", 32'(nv), 32'b000011);
`else
        chk("t1_pat_p", 32'(pv), 32'b111000);
        chk("t1_pat_n", 32'(nv), 32'b000111);
`endif

        // ch1 QUAD div=0
        wr(1, 2, 0);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            qv[15-4*i -: 4] = {lo_p[1], lo_qp[1], lo_n[1], lo_qn[1]};
        end
`ifdef LO_DEADTIME_EN
        chk("t2_quad", 32'(qv), 32'h0000);
`else
        chk("t2_quad", 32'(qv), 32'b1000_0100_0010_0001);
`endif

        // ch0 retune while running
        wr(0, 1, 3);
        repeat (3) @(negedge clk);
        wr(0, 1, 1);
        repeat (20) @(negedge clk);

        // ch0 external LO
        ext_lo_p[0] = 1'b1;
        wr(0, 3, 0);
        repeat (4) @(posedge clk);
        #2;
        chk("t4_follow", 32'({lo_p[0], lo_n[0]}), 32'b10);
        @(negedge clk);
        ext_lo_n[0] = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("t4_bbm", 32'({lo_p[0], lo_n[0]}), 32'b00);
        @(negedge clk);
        ext_lo_p[0] = 1'b0;
        ext_lo_n[0] = 1'b0;

        // two channels aligned by sync_i
        wr(0, 1, 4);
        repeat (3) @(negedge clk);
        wr(1, 1, 4);
        repeat (7) @(negedge clk);
        sync_i = 1'b1;
        @(negedge clk);
        sync_i = 1'b0;
        repeat (12) @(negedge clk);

        // reset mid-RUN with a pending write
        wr(0, 2, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_lo", 32'({lo_p, lo_n, lo_qp, lo_qn}), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(cfg_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cfg_valid = ($urandom % 4) == 0;
            cfg_ch    = 1'($urandom % 2);
            cfg_mode  = 2'($urandom % 4);
            cfg_div   = (($urandom % 16) == 0) ? DW'($urandom % 12) : DW'($urandom % 4);
            sync_i    = ($urandom % 30) == 0;
            for (int c = 0; c < N; c++) begin
                if (($urandom % 3) == 0) ext_lo_p[c] = ~ext_lo_p[c];
                if (($urandom % 3) == 0) ext_lo_n[c] = ~ext_lo_n[c];
            end
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        sync_i    = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
